noc_packet_injector: RTL and testbench
======================================

// Module: noc_packet_injector
// PURPOSE
//  Network-interface source stage feeding a router's local injection port (port 4: idata/ivalid/ivch/ordy).
//  Accepts a packet request (destination, VC, length) plus a payload word stream from the host side.
//  Segments each packet into 35-bit flits (head/body/tail) and launches them under per-VC ready.
//  One instance per mesh node; its odata/ovalid/ovch drive the router's idata_4/ivalid_4/ivch_4; ordy_4 returns as ordy.
// PARAMETERS
//  XW      2   width of x and y coordinates
//  LENW    8   width of req_len (payload words per packet, 0..2^LENW-1)
//  CNTW    16  width of pkt_cnt status counter
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  rst         in   1       asynchronous, active-high reset
//  my_xpos     in   XW      this node's x coordinate (static)
//  my_ypos     in   XW      this node's y coordinate (static)
//  req_valid   in   1       packet request valid
//  req_ready   out  1       packet request accepted when valid&ready
//  req_dst_x   in   XW      destination x
//  req_dst_y   in   XW      destination y
//  req_vch     in   1       virtual channel for whole packet
//  req_len     in   LENW    number of 32-bit payload words
//  pl_valid    in   1       payload word valid
//  pl_ready    out  1       payload word accepted when valid&ready
//  pl_data     in   32      payload word
//  odata       out  35      flit to router
//  ovalid      out  1       flit valid
//  ovch        out  1       flit VC
//  ordy        in   2       per-VC ready from router; bit [ovch] qualifies transfer
//  busy        out  1       packet in progress or flit pending
//  pkt_cnt     out  CNTW    packets fully launched (tail accepted), wraps
// BEHAVIOUR
//  Flit format: [34:32] type: 3'b001 head, 3'b010 body, 3'b011 tail, 3'b100 head_tail; [31:0] data.
//  Head data = {zero-pad, len[LENW-1:0], my_ypos, my_xpos, dst_y, dst_x} (dst_x at LSBs).
//  len=0 -> single head_tail flit. len=N>=1 -> head, N-1 body flits (words 1..N-1), tail (word N).
//  Transfer ("accept") = ovalid & ordy[ovch]. odata/ovalid/ovch are registered outputs.
//  While ovalid=1 and not accepted, odata/ovch remain stable (no withdrawal).
//  out_free = ~ovalid | accept. A new flit loads into the output register on the edge where out_free=1.
//  FSM: IDLE, BODY.
//   IDLE: req_ready = out_free. On req accept: load head (or head_tail if len=0), latch vch/len,
//         words_left<=len; go BODY if len>0, else stay IDLE.
//   BODY: pl_ready = out_free; req_ready=0. On pl accept: load body flit if words_left>1, else tail;
//         words_left decrements; on tail load -> IDLE.
//  Throughput: one flit per cycle when ordy[vch] held high and pl_valid held high (head + N words = N+1 cycles).
//  All flits of a packet use the VC latched at request; req_vch ignored mid-packet.
//  ordy[~ovch] has no effect. ordy toggling while ovalid=0 has no effect.
//  pkt_cnt increments by 1 on accept of a tail or head_tail flit; wraps all-ones -> 0.
//  busy = (state==BODY) | ovalid.
//  Reset (async, any time incl. mid-packet): state IDLE, ovalid=0, odata=0, ovch=0, words_left=0,
//   pkt_cnt=0, req_ready and pl_ready deassert immediately; any partial packet is discarded.
//  req_valid during BODY is held off (req_ready=0); pl_valid in IDLE is held off (pl_ready=0).
// TESTING
//  1. my=(0,0); req dst=(1,0) vch=0 len=0, ordy=2'b11 -> one flit type 100, data[7:0]=8'h01 after 1 clk; pkt_cnt=1.
//  2. len=3, words A,B,C, ordy=11, pl_valid always -> head,body(A),body(B),tail(C) on 4 consecutive cycles; pkt_cnt=1.
//  3. len=2 vch=1, ordy=2'b01 for 5 cycles then 2'b11 -> head held stable with ovalid=1 for 5 cycles, no pl accept, then head,body,tail.
//  4. pl_valid gaps (1 of every 2 cycles) during len=4 -> no bubble flits, ovalid low in gaps, 4 payload flits in order.
//  5. rst pulsed after 2nd body flit of len=5 -> ovalid=0, pkt_cnt=0 asynchronously; next req len=1 produces clean head+tail.
//  6. 65536 len=0 packets back-to-back -> pkt_cnt wraps to 0; req_ready never drops while ordy=11.

Source files
------------

// File: rtl/noc_packet_injector.sv
// Network-interface source stage: turns a packet request plus a payload word
// stream into head/body/tail flits for a router's local injection port.
module noc_packet_injector #(
    parameter int XW   = 2,
    parameter int LENW = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XW-1:0]   my_xpos,
    input  logic [XW-1:0]   my_ypos,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XW-1:0]   req_dst_x,
    input  logic [XW-1:0]   req_dst_y,
    input  logic            req_vch,
    input  logic [LENW-1:0] req_len,
    input  logic            pl_valid,
    output logic            pl_ready,
    input  logic [31:0]     pl_data,
    output logic [34:0]     odata,
    output logic            ovalid,
    output logic            ovch,
    input  logic [1:0]      ordy,
    output logic            busy,
    output logic [CNTW-1:0] pkt_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    localparam logic [2:0] T_HEAD = 3'b001;
    localparam logic [2:0] T_BODY = 3'b010;
    localparam logic [2:0] T_TAIL = 3'b011;
    localparam logic [2:0] T_HT   = 3'b100;

    logic [0:0]      state;
    logic [LENW-1:0] words_left;
    logic            vch_q;
    logic            accept;
    logic            out_free;
    logic            req_fire;
    logic            pl_fire;
    logic            last_out;
    logic [31:0]     head_data;

    assign accept   = ovalid & ordy[ovch];
    // The output register can take a new flit if it is empty or draining this cycle.
    assign out_free = ~ovalid | accept;

    assign req_ready = ~rst & (state == S_IDLE) & out_free;
    assign pl_ready  = ~rst & (state == S_BODY) & out_free;
    assign req_fire  = req_valid & req_ready;
    assign pl_fire   = pl_valid & pl_ready;

    assign last_out = (odata[34:32] == T_TAIL) | (odata[34:32] == T_HT);
    assign busy     = (state == S_BODY) | ovalid;

    always_comb begin
        head_data = '0;
        head_data[LENW+4*XW-1:0] = {req_len, my_ypos, my_xpos, req_dst_y, req_dst_x};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            words_left <= '0;
            vch_q      <= 1'b0;
            odata      <= '0;
            ovalid     <= 1'b0;
            ovch       <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            if (req_fire) begin
                odata      <= {(req_len == '0) ? T_HT : T_HEAD, head_data};
                ovalid     <= 1'b1;
                ovch       <= req_vch;
                vch_q      <= req_vch;
                words_left <= req_len;
                state      <= (req_len != '0) ? S_BODY : S_IDLE;
            end else if (pl_fire) begin
                odata      <= {(words_left > LENW'(1)) ? T_BODY : T_TAIL, pl_data};
                ovalid     <= 1'b1;
                ovch       <= vch_q;
                words_left <= words_left - LENW'(1);
                if (words_left <= LENW'(1))
                    state <= S_IDLE;
            end else if (accept) begin
                ovalid <= 1'b0;
            end

            if (accept && last_out)
                pkt_cnt <= pkt_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Randomized bench for noc_packet_injector: expected flit stream is built per
// packet from the request fields and payload words, then matched on each accept.
module tb_noc_packet_injector;

    localparam int XW   = 2;
    localparam int LENW = 8;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [XW-1:0]   my_xpos, my_ypos;
    logic            req_valid, req_ready;
    logic [XW-1:0]   req_dst_x, req_dst_y;
    logic            req_vch;
    logic [LENW-1:0] req_len;
    logic            pl_valid, pl_ready;
    logic [31:0]     pl_data;
    logic [34:0]     odata;
    logic            ovalid, ovch;
    logic [1:0]      ordy;
    logic            busy;
    logic [CNTW-1:0] pkt_cnt;

    noc_packet_injector #(.XW(XW), .LENW(LENW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .my_xpos(my_xpos), .my_ypos(my_ypos),
        .req_valid(req_valid), .req_ready(req_ready), .req_dst_x(req_dst_x),
        .req_dst_y(req_dst_y), .req_vch(req_vch), .req_len(req_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .odata(odata), .ovalid(ovalid), .ovch(ovch), .ordy(ordy),
        .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [35:0]     exp_q[$];      // {vch, type, data}
    logic [CNTW-1:0] exp_cnt;
    bit              rand_rdy = 0;
    int              stall_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) ordy = 2'($urandom);
    endtask

    // Monitor: checks at negedge, where this cycle's accept is already decided.
    initial begin
        logic [35:0] f;
        logic [34:0] prev_data;
        logic        prev_vch;
        bit          prev_hold;
        prev_hold = 0;
        prev_data = '0;
        prev_vch  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", ovalid, 1);
                    chk("hold_flit", {ovch, odata}, {prev_vch, prev_data});
                end
                chk("pkt_cnt", pkt_cnt, exp_cnt);
                chk("busy", busy, exp_q.size() != 0);
                if (ovalid && ordy[ovch]) begin
                    chk("flit_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        f = exp_q.pop_front();
                        chk("flit", {ovch, odata}, f);
                        if (f[34:32] == 3'b011 || f[34:32] == 3'b100)
                            exp_cnt = exp_cnt + 1'b1;
                    end
                end
                prev_hold = ovalid && !ordy[ovch];
                prev_data = odata;
                prev_vch  = ovch;
            end
        end
    end

    // gap: 0 none, 1 one idle cycle before every word, 2 random idles.
    // abort_at >= 0 returns after that many payload words were accepted.
    task automatic send_pkt(input logic [XW-1:0] dx, input logic [XW-1:0] dy,
                            input logic v, input int len, input int gap, input int abort_at);
        logic [31:0] w[$];
        logic [31:0] hd;
        bit          acc;
        int          cyc;
        for (int i = 0; i < len; i++) w.push_back($urandom);
        req_dst_x = dx; req_dst_y = dy; req_vch = v; req_len = LENW'(len);
        req_valid = 1'b1;
        pl_valid  = 1'b1;                // must be held off while idle
        pl_data   = $urandom;
        cyc = 0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            if (!acc) stall_cnt++;
            tick();
            if (acc) break;
            if (++cyc >= 400) begin
                chk("req_wait", acc, 1);
                req_valid = 1'b0; pl_valid = 1'b0;
                return;
            end
        end
        hd = (32'(len) << (4*XW)) | (32'(my_ypos) << (3*XW)) | (32'(my_xpos) << (2*XW))
           | (32'(dy) << XW) | 32'(dx);
        exp_q.push_back({v, (len == 0) ? 3'b100 : 3'b001, hd});
        for (int i = 0; i < len; i++)
            exp_q.push_back({v, (i == len - 1) ? 3'b011 : 3'b010, w[i]});
        // Stray requests while the packet body is in flight must be held off.
        req_valid = (len > 0);
        req_dst_x = XW'($urandom); req_vch = 1'($urandom); req_len = LENW'($urandom);
        pl_valid  = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                req_valid = 1'b0; pl_valid = 1'b0;
                return;
            end
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                pl_valid = 1'b0; pl_data = $urandom;
                tick();
            end
            pl_valid = 1'b1; pl_data = w[i];
            cyc = 0;
            forever begin
                @(negedge clk);
                acc = pl_ready;
                tick();
                if (acc) break;
                if (++cyc >= 400) begin
                    chk("pl_wait", acc, 1);
                    req_valid = 1'b0; pl_valid = 1'b0;
                    return;
                end
            end
        end
        req_valid = 1'b0;
        pl_valid  = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while ((busy || exp_q.size() != 0) && c < 500) begin
            tick();
            c++;
        end
        chk("drain", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        my_xpos = '0; my_ypos = '0;
        req_valid = 1'b0; req_dst_x = '0; req_dst_y = '0; req_vch = 1'b0; req_len = '0;
        pl_valid = 1'b0; pl_data = '0; ordy = 2'b00;
        exp_cnt = '0;
        #12;
        chk("rst_ovalid", ovalid, 0);
        chk("rst_odata", odata, 0);
        chk("rst_ovch", ovch, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_pl_ready", pl_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ordy = 2'b11;

        // single head_tail flit, visible one clock after the request
        send_pkt(2'd1, 2'd0, 1'b0, 0, 0, -1);
        chk("t1_flit", odata, 35'h4_0000_0001);
        drain();
        chk("t1_cnt", pkt_cnt, 1);

        // len=3, back-to-back
        send_pkt(2'd2, 2'd3, 1'b0, 3, 0, -1);
        drain();
        chk("t2_cnt", pkt_cnt, 2);

        // head stalls on VC1 for five cycles while VC0 is ready
        ordy = 2'b01;
        fork
            send_pkt(2'd1, 2'd1, 1'b1, 2, 0, -1);
            begin
                @(posedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk("t3_hold_valid", ovalid, 1);
                    chk("t3_no_pl", pl_ready, 0);
                end
                @(posedge clk); #1;
                ordy = 2'b11;
            end
        join
        drain();

        // payload with gaps
        send_pkt(2'd3, 2'd2, 1'b0, 4, 1, -1);
        drain();
        chk("t4_cnt", pkt_cnt, 4);

        // async reset mid-packet
        send_pkt(2'd2, 2'd2, 1'b1, 5, 0, 2);
        #1 rst = 1'b1;
        #1;
        chk("t5_ovalid", ovalid, 0);
        chk("t5_pkt_cnt", pkt_cnt, 0);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_pl_ready", pl_ready, 0);
        chk("t5_busy", busy, 0);
        exp_q.delete();
        exp_cnt = '0;
        tick(); tick();
        rst = 1'b0;
        send_pkt(2'd1, 2'd2, 1'b0, 1, 0, -1);
        drain();
        chk("t5_cnt", pkt_cnt, 1);

        // randomized traffic with random per-VC ready
        my_xpos = XW'($urandom); my_ypos = XW'($urandom);
        rand_rdy = 1;
        repeat (300) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
            send_pkt(XW'($urandom), XW'($urandom), 1'($urandom), len, 2, -1);
        end
        rand_rdy = 0;
        ordy = 2'b11;
        drain();

        // counter wrap with back-to-back single-flit packets
        rst = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        tick();
        rst = 1'b0;
        stall_cnt = 0;
        repeat (65536) send_pkt(XW'($urandom), XW'($urandom), 1'($urandom), 0, 0, -1);
        drain();
        chk("t6_wrap", pkt_cnt, 0);
        chk("t6_no_stall", stall_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
